// File: rtl/param_seq_pkg.sv
// Shared types and helpers for the parametrised phase sequencer.
// Provides the control enum, index-width helper and circular next-enabled search.
package param_seq_pkg;

  localparam int unsigned MAX_STATES = 64;
  localparam int unsigned MAX_IDX_W  = 6;

  // Two-bit encoding leaves 2'b10/2'b11 as detectable illegal values.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01
  } ctrl_t;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] target;
  } next_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Circular search starting at idx+1; the loop runs from far to near so the
  // nearest enabled state is the last one written.
  function automatic next_t next_enabled(input logic [MAX_STATES-1:0] mask,
                                         input logic [MAX_IDX_W-1:0]  idx,
                                         input int unsigned           n);
    next_t              res;
    logic [MAX_IDX_W:0] j;
    res = '0;
    for (int k = MAX_STATES; k >= 1; k--) begin
      j = {1'b0, idx} + (MAX_IDX_W+1)'(k);
      if (j >= (MAX_IDX_W+1)'(n)) j = j - (MAX_IDX_W+1)'(n);
      if ((k <= int'(n)) && mask[j[MAX_IDX_W-1:0]]) begin
        res.found  = 1'b1;
        res.target = j[MAX_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/param_seq_fsm_if.sv
// Control/status bundle between CSR block (master) and the sequencer (slave).
// PARAM_SEQ_ONEHOT_EN adds the one-hot phase output state_oh.
interface param_seq_fsm_if #(
  parameter int unsigned NUM_STATES = 3,
  parameter int unsigned IDX_W      = param_seq_pkg::idx_width(NUM_STATES),
  parameter int unsigned DWELL_W    = 8
);
  logic                  start;
  logic                  abort;
  logic                  step;
  logic [DWELL_W-1:0]    dwell;
  logic [NUM_STATES-1:0] state_mask;
  logic                  busy;
  logic [IDX_W-1:0]      state_idx;
  logic                  adv;
  logic                  wrap;
  logic                  done;
  logic                  err_empty;
  logic                  illegal_seen;
`ifdef PARAM_SEQ_ONEHOT_EN
  logic [NUM_STATES-1:0] state_oh;

  modport master (
    output start, abort, step, dwell, state_mask,
    input  busy, state_idx, adv, wrap, done, err_empty, illegal_seen, state_oh
  );
  modport slave (
    input  start, abort, step, dwell, state_mask,
    output busy, state_idx, adv, wrap, done, err_empty, illegal_seen, state_oh
  );
`else
  modport master (
    output start, abort, step, dwell, state_mask,
    input  busy, state_idx, adv, wrap, done, err_empty, illegal_seen
  );
  modport slave (
    input  start, abort, step, dwell, state_mask,
    output busy, state_idx, adv, wrap, done, err_empty, illegal_seen
  );
`endif
endinterface

// File: rtl/seq_dwell_ctr.sv
// Per-state dwell counter: clears and latches the dwell target on state entry,
// then counts up (saturating) and reports when the minimum dwell is met.
module seq_dwell_ctr #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell,
  output logic               satisfied
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;

  always_comb begin
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    if (load) begin
      cnt_d   = '0;
      dwell_d = dwell;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      dwell_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
    end
  end

  assign satisfied = (cnt_q >= dwell_q);

endmodule

// File: rtl/param_seq_fsm.sv
// Circular phase sequencer over NUM_STATES maskable states with minimum dwell.
// Optional PARAM_SEQ_ONEHOT_EN adds a registered one-hot phase output.
module param_seq_fsm
  import param_seq_pkg::*;
#(
  parameter int unsigned NUM_STATES = 3,
  parameter int unsigned IDX_W      = idx_width(NUM_STATES),
  parameter int unsigned DWELL_W    = 8,
  parameter int unsigned ONE_SHOT   = 0
) (
  input logic            clk,
  input logic            rst,
  param_seq_fsm_if.slave bus
);

  ctrl_t                 ctrl_q, ctrl_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  illegal_q;
  logic                  illegal;
  logic                  load;
  logic                  satisfied;
  logic                  adv, wrap, done, err_empty;
  logic                  wrap_c;
  logic [MAX_STATES-1:0] mask_ext;
  logic [MAX_IDX_W-1:0]  search_from;
  next_t                 nxt;

  // From IDLE the search starts just past the last index so it lands on the lowest set bit.
  always_comb begin
    mask_ext                   = '0;
    mask_ext[NUM_STATES-1:0]   = bus.state_mask;
    search_from = (ctrl_q == RUN) ? MAX_IDX_W'(idx_q) : MAX_IDX_W'(NUM_STATES - 1);
    nxt         = next_enabled(mask_ext, search_from, NUM_STATES);
    wrap_c      = (nxt.target <= MAX_IDX_W'(idx_q));
    illegal     = ((ctrl_q != IDLE) && (ctrl_q != RUN)) || (32'(idx_q) >= NUM_STATES);
  end

  always_comb begin
    ctrl_d    = ctrl_q;
    idx_d     = idx_q;
    load      = 1'b0;
    adv       = 1'b0;
    wrap      = 1'b0;
    done      = 1'b0;
    err_empty = 1'b0;
    if (illegal) begin
      ctrl_d = IDLE;
      idx_d  = '0;
    end else if (bus.abort) begin
      ctrl_d = IDLE;
      idx_d  = '0;
    end else begin
      unique case (ctrl_q)
        IDLE: begin
          if (bus.start) begin
            if (nxt.found) begin
              ctrl_d = RUN;
              idx_d  = nxt.target[IDX_W-1:0];
              load   = 1'b1;
            end else begin
              err_empty = 1'b1;
            end
          end
        end
        RUN: begin
          if (bus.step && satisfied) begin
            if (!nxt.found) begin
              ctrl_d    = IDLE;
              idx_d     = '0;
              err_empty = 1'b1;
            end else begin
              adv  = 1'b1;
              wrap = wrap_c;
              if ((ONE_SHOT != 0) && wrap_c) begin
                ctrl_d = IDLE;
                idx_d  = '0;
                done   = 1'b1;
              end else begin
                idx_d = nxt.target[IDX_W-1:0];
                load  = 1'b1;
              end
            end
          end
        end
        default: begin
          ctrl_d = IDLE;
          idx_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q    <= IDLE;
      idx_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      idx_q  <= idx_d;
      if (illegal) illegal_q <= 1'b1;
    end
  end

  seq_dwell_ctr #(
    .DWELL_W(DWELL_W)
  ) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .en       (ctrl_q == RUN),
    .dwell    (bus.dwell),
    .satisfied(satisfied)
  );

  assign bus.busy         = (ctrl_q == RUN);
  assign bus.state_idx    = idx_q;
  assign bus.adv          = adv;
  assign bus.wrap         = wrap;
  assign bus.done         = done;
  assign bus.err_empty    = err_empty;
  assign bus.illegal_seen = illegal_q;

`ifdef PARAM_SEQ_ONEHOT_EN
  logic [NUM_STATES-1:0] oh_q, oh_d;

  always_comb begin
    oh_d = '0;
    if (ctrl_d == RUN) oh_d[idx_d] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) oh_q <= '0;
    else     oh_q <= oh_d;
  end

  assign bus.state_oh = oh_q;
`endif

endmodule

// File: tb/tb_param_seq_fsm.sv
// Directed bench for param_seq_fsm: vector table plus hand-written reset,
// illegal-index and one-shot sequences on NUM_STATES=3 instances.
module tb_param_seq_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  param_seq_fsm_if #(.NUM_STATES(3)) bus0 ();
  param_seq_fsm_if #(.NUM_STATES(3)) bus1 ();

  param_seq_fsm #(.NUM_STATES(3), .ONE_SHOT(0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus0)
  );

  param_seq_fsm #(.NUM_STATES(3), .ONE_SHOT(1)) dut1 (
    .clk(clk),
    .rst(rst),
    .bus(bus1)
  );

  typedef struct {
    logic       sel;
    logic       start, abort, step;
    logic [7:0] dwell;
    logic [2:0] mask;
    logic       busy;
    logic [1:0] idx;
    logic       adv, wrap, done, err;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input int s, input int st, input int ab, input int sp,
                              input int dw, input int m, input int b, input int ix,
                              input int a, input int w, input int d, input int e);
    vec_t v;
    v.sel = 1'(s);  v.start = 1'(st); v.abort = 1'(ab); v.step = 1'(sp);
    v.dwell = 8'(dw); v.mask = 3'(m);
    v.busy = 1'(b); v.idx = 2'(ix); v.adv = 1'(a); v.wrap = 1'(w);
    v.done = 1'(d); v.err = 1'(e);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic sel, input logic st, input logic ab, input logic sp,
                       input logic [7:0] dw, input logic [2:0] m);
    bus0.start = 1'b0; bus0.abort = 1'b0; bus0.step = 1'b0; bus0.dwell = '0;
    bus0.state_mask = '0;
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.step = 1'b0; bus1.dwell = '0;
    bus1.state_mask = '0;
    if (!sel) begin
      bus0.start = st; bus0.abort = ab; bus0.step = sp; bus0.dwell = dw; bus0.state_mask = m;
    end else begin
      bus1.start = st; bus1.abort = ab; bus1.step = sp; bus1.dwell = dw; bus1.state_mask = m;
    end
  endtask

  task automatic check_outs(input string tag, input logic sel, input logic busy,
                            input logic [1:0] idx, input logic adv, input logic wrap,
                            input logic done, input logic err, input logic ill);
    logic       g_busy, g_adv, g_wrap, g_done, g_err, g_ill;
    logic [1:0] g_idx;
    if (!sel) begin
      g_busy = bus0.busy; g_idx = bus0.state_idx; g_adv = bus0.adv; g_wrap = bus0.wrap;
      g_done = bus0.done; g_err = bus0.err_empty; g_ill = bus0.illegal_seen;
    end else begin
      g_busy = bus1.busy; g_idx = bus1.state_idx; g_adv = bus1.adv; g_wrap = bus1.wrap;
      g_done = bus1.done; g_err = bus1.err_empty; g_ill = bus1.illegal_seen;
    end
    chk({tag, " busy"}, 32'(g_busy), 32'(busy));
    chk({tag, " idx"},  32'(g_idx),  32'(idx));
    chk({tag, " adv"},  32'(g_adv),  32'(adv));
    chk({tag, " wrap"}, 32'(g_wrap), 32'(wrap));
    chk({tag, " done"}, 32'(g_done), 32'(done));
    chk({tag, " err_empty"}, 32'(g_err), 32'(err));
    chk({tag, " illegal_seen"}, 32'(g_ill), 32'(ill));
`ifdef PARAM_SEQ_ONEHOT_EN
    begin
      logic [2:0] exp_oh;
      exp_oh = busy ? (3'b001 << idx) : 3'b000;
      chk({tag, " state_oh"}, sel ? 32'(bus1.state_oh) : 32'(bus0.state_oh), 32'(exp_oh));
    end
`endif
  endtask

  initial begin
    // sel,start,abort,step,dwell,mask | busy,idx,adv,wrap,done,err
    vecs.push_back(mk(0,1,0,0,0,3'b101, 0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,1,0,3'b101, 1,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,1,0,3'b101, 1,2,1,1,0,0));
    vecs.push_back(mk(0,0,0,1,0,3'b101, 1,0,1,0,0,0));
    vecs.push_back(mk(0,0,0,1,0,3'b101, 1,2,1,1,0,0));
    vecs.push_back(mk(0,0,1,1,0,3'b101, 1,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,3'b101, 0,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,3'b000, 0,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,3'b000, 0,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,4,3'b111, 0,0,0,0,0,0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0,0,0,1,4,3'b111, 1,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,1,0,3'b111, 1,0,1,0,0,0));
    vecs.push_back(mk(0,0,1,1,0,3'b111, 1,1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,3'b111, 0,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,3'b010, 0,0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,3'b001, 1,1,0,0,0,0));
    vecs.push_back(mk(0,0,0,1,0,3'b001, 1,1,1,1,0,0));
    vecs.push_back(mk(0,0,0,1,0,3'b001, 1,0,1,1,0,0));
    vecs.push_back(mk(0,0,0,1,0,3'b000, 1,0,0,0,0,1));
    vecs.push_back(mk(0,0,0,0,0,3'b000, 0,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,3'b100, 0,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,0,3'b011, 1,2,0,0,0,0));
    vecs.push_back(mk(0,0,1,0,0,3'b011, 1,2,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,0,3'b011, 0,0,0,0,0,0));
    vecs.push_back(mk(1,1,0,0,0,3'b111, 0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,1,0,3'b111, 1,0,1,0,0,0));
    vecs.push_back(mk(1,0,0,1,0,3'b111, 1,1,1,0,0,0));
    vecs.push_back(mk(1,0,0,1,0,3'b111, 1,2,1,1,1,0));
    vecs.push_back(mk(1,0,0,0,0,3'b111, 0,0,0,0,0,0));

    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'b000);
    #12;
    check_outs("reset dut", 1'b0, 0, 2'd0, 0, 0, 0, 0, 0);
    check_outs("reset dut1", 1'b1, 0, 2'd0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].sel, vecs[i].start, vecs[i].abort, vecs[i].step, vecs[i].dwell,
            vecs[i].mask);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].sel, vecs[i].busy, vecs[i].idx,
                 vecs[i].adv, vecs[i].wrap, vecs[i].done, vecs[i].err, 1'b0);
    end

    // Async reset while running at idx 2.
    @(negedge clk); drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 3'b111);
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 3'b111);
    @(negedge clk);
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'b111);
    #1 check_outs("pre-rst", 1'b0, 1, 2'd2, 0, 0, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 3'b111);
    rst = 1'b1;
    #1 check_outs("rst mid-run", 1'b0, 0, 2'd0, 0, 0, 0, 0, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'b111);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_outs($sformatf("post-rst idle%0d", i), 1'b0, 0, 2'd0, 0, 0, 0, 0, 0);
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 3'b111);
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'b111);
    #1 check_outs("restart", 1'b0, 1, 2'd0, 0, 0, 0, 0, 0);

    // Illegal index deposited while running.
    @(negedge clk);
    dut.idx_q = 2'd3;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 3'b111);
    #1 chk("illegal cycle adv", 32'(bus0.adv), 32'd0);
    chk("illegal cycle wrap", 32'(bus0.wrap), 32'd0);
    @(posedge clk); #1;
    check_outs("after illegal", 1'b0, 0, 2'd0, 0, 0, 0, 0, 1);
    @(negedge clk); drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 3'b010);
    @(negedge clk); drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 3'b010);
    #1 check_outs("illegal sticky", 1'b0, 1, 2'd1, 0, 0, 0, 0, 1);
    rst = 1'b1;
    #1 chk("illegal cleared by rst", 32'(bus0.illegal_seen), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
